// File: rtl/fifo_flex.sv
// Single-clock FIFO with arbitrary depth, standard or first-word fall-through
// read, fill count, almost-full/almost-empty thresholds, sticky error flags
// and a synchronous flush. Dropped accesses only raise the sticky flags.
module fifo_flex #(
  parameter int WORD_WDT   = 64,
  parameter int FIFO_DEPTH = 8,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 1,
  localparam int CNT_WDT   = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                fifo_wr,
  input  logic [WORD_WDT-1:0] in_word,
  output logic                fifo_full,
  output logic                fifo_almost_full,
  input  logic                fifo_rd,
  output logic [WORD_WDT-1:0] out_word,
  output logic                out_valid,
  output logic                fifo_empty,
  output logic                fifo_almost_empty,
  output logic [CNT_WDT-1:0]  fifo_cnt,
  output logic                err_ovf,
  output logic                err_udf
);

  localparam int PTR_WDT = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_WDT-1:0] PTR_LAST = PTR_WDT'(FIFO_DEPTH - 1);
  localparam logic [CNT_WDT-1:0] CNT_FULL = CNT_WDT'(FIFO_DEPTH);
  localparam logic [CNT_WDT-1:0] CNT_AF   = CNT_WDT'(AF_THRESH);
  localparam logic [CNT_WDT-1:0] CNT_AE   = CNT_WDT'(AE_THRESH);

  if (FIFO_DEPTH < 2 || AE_THRESH < 0 || AE_THRESH >= AF_THRESH || AF_THRESH > FIFO_DEPTH)
  begin : g_bad_param
    $error("fifo_flex: need FIFO_DEPTH>=2 and 0 <= AE_THRESH < AF_THRESH <= FIFO_DEPTH");
  end

  logic [WORD_WDT-1:0] mem_q [FIFO_DEPTH];

  logic [PTR_WDT-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_WDT-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_WDT-1:0]  cnt_q, cnt_d;
  logic [WORD_WDT-1:0] rd_word_q, rd_word_d;
  logic                rd_valid_q, rd_valid_d;
  logic                ovf_q, ovf_d;
  logic                udf_q, udf_d;

  logic wr_acc;
  logic rd_acc;

  // Flags depend only on the registered count.
  assign fifo_full         = (cnt_q == CNT_FULL);
  assign fifo_empty        = (cnt_q == '0);
  assign fifo_almost_full  = (cnt_q >= CNT_AF);
  assign fifo_almost_empty = (cnt_q <= CNT_AE);
  assign fifo_cnt          = cnt_q;
  assign err_ovf           = ovf_q;
  assign err_udf           = udf_q;

  // Flush swallows any access in the same cycle, so it gates acceptance here.
  assign wr_acc = fifo_wr & ~fifo_full  & ~flush;
  assign rd_acc = fifo_rd & ~fifo_empty & ~flush;

  // Next-state: pointers wrap by explicit compare since depth need not be 2^n.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    rd_word_d  = rd_word_q;
    rd_valid_d = 1'b0;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      if (rd_acc) begin
        rd_ptr_d   = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        rd_word_d  = mem_q[rd_ptr_q];
        rd_valid_d = 1'b1;
      end
      cnt_d = cnt_q + CNT_WDT'(wr_acc) - CNT_WDT'(rd_acc);
      if (fifo_wr & fifo_full)  ovf_d = 1'b1;
      if (fifo_rd & fifo_empty) udf_d = 1'b1;
    end
  end

  // Control and read-data registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      rd_word_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      rd_word_q  <= rd_word_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  // Storage array is not reset; contents are meaningless after reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= in_word;
  end

  // FWFT shows the head word directly; it is forced to zero while empty so the
  // output is defined out of reset even though the array is not.
  if (FWFT != 0) begin : g_fwft
    assign out_word  = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign out_valid = ~fifo_empty;
  end else begin : g_std
    assign out_word  = rd_word_q;
    assign out_valid = rd_valid_q;
  end

`ifndef SYNTHESIS
  // Simulation-only sanity checks on count range and flag definedness.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (cnt_q <= CNT_FULL) else $error("fifo_flex: count exceeds depth");
      assert (!$isunknown({fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty,
                           ovf_q, udf_q, out_valid}))
        else $error("fifo_flex: unknown value on a flag");
    end
  end
`endif

endmodule

// File: tb/tb_fifo_flex.sv
// Bench for fifo_flex: a standard-mode and an FWFT instance share stimulus and
// are compared against a queue-based model, a hand-written vector table and
// directed corner-case sequences.
module tb_fifo_flex;
  localparam int W  = 16;
  localparam int D  = 6;
  localparam int AF = 5;
  localparam int AE = 1;
  localparam int CW = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         fifo_wr = 1'b0;
  logic         fifo_rd = 1'b0;
  logic [W-1:0] in_word = '0;

  logic s_full, s_af, s_ov, s_empty, s_ae, s_ovf, s_udf;
  logic f_full, f_af, f_ov, f_empty, f_ae, f_ovf, f_udf;
  logic [W-1:0]  s_ow, f_ow;
  logic [CW-1:0] s_cnt, f_cnt;

  fifo_flex #(.WORD_WDT(W), .FIFO_DEPTH(D), .FWFT(0), .AF_THRESH(AF), .AE_THRESH(AE)) u_std (
    .clk(clk), .rst_n(rst_n), .flush(flush), .fifo_wr(fifo_wr), .in_word(in_word),
    .fifo_full(s_full), .fifo_almost_full(s_af), .fifo_rd(fifo_rd), .out_word(s_ow),
    .out_valid(s_ov), .fifo_empty(s_empty), .fifo_almost_empty(s_ae), .fifo_cnt(s_cnt),
    .err_ovf(s_ovf), .err_udf(s_udf));

  fifo_flex #(.WORD_WDT(W), .FIFO_DEPTH(D), .FWFT(1), .AF_THRESH(AF), .AE_THRESH(AE)) u_fwft (
    .clk(clk), .rst_n(rst_n), .flush(flush), .fifo_wr(fifo_wr), .in_word(in_word),
    .fifo_full(f_full), .fifo_almost_full(f_af), .fifo_rd(fifo_rd), .out_word(f_ow),
    .out_valid(f_ov), .fifo_empty(f_empty), .fifo_almost_empty(f_ae), .fifo_cnt(f_cnt),
    .err_ovf(f_ovf), .err_udf(f_udf));

  always #5 clk = ~clk;

  // Reference model: contents as a queue, plus sticky flags and STD read register.
  logic [W-1:0] mq[$];
  bit           m_ovf, m_udf, m_ov;
  logic [W-1:0] m_ow;

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    bit wr, rd, fl;
    logic [W-1:0] din;
    int cnt;
    bit full, af, empty, ae, ovf, udf, ov;
    logic [W-1:0] ow;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_udf = 0; m_ov = 0; m_ow = '0;
  endtask

  task automatic model_step(bit wr, bit rd, bit fl, logic [W-1:0] d);
    int sz;
    sz = mq.size();
    if (fl) begin
      mq.delete(); m_ovf = 0; m_udf = 0; m_ov = 0;
    end else begin
      if (wr && sz == D) m_ovf = 1;
      if (rd && sz == 0) m_udf = 1;
      if (rd && sz != 0) begin
        m_ow = mq.pop_front(); m_ov = 1;
      end else m_ov = 0;
      if (wr && sz != D) mq.push_back(d);
    end
  endtask

  task automatic check_model();
    int sz;
    sz = mq.size();
    chk("cnt", 32'(s_cnt), sz);
    chk("full", s_full, sz == D);
    chk("almost_full", s_af, sz >= AF);
    chk("empty", s_empty, sz == 0);
    chk("almost_empty", s_ae, sz <= AE);
    chk("err_ovf", s_ovf, m_ovf);
    chk("err_udf", s_udf, m_udf);
    chk("std_out_valid", s_ov, m_ov);
    chk("std_out_word", s_ow, m_ow);
    chk("fwft_cnt", 32'(f_cnt), sz);
    chk("fwft_err", {f_ovf, f_udf}, {m_ovf, m_udf});
    chk("fwft_out_valid", f_ov, sz != 0);
    if (sz != 0) chk("fwft_out_word", f_ow, mq[0]);
  endtask

  // Drive at the falling edge, let one rising edge pass, check 1 ns later.
  task automatic step(bit wr, bit rd, bit fl, logic [W-1:0] d);
    fifo_wr = wr; fifo_rd = rd; flush = fl; in_word = d;
    @(posedge clk);
    model_step(wr, rd, fl, d);
    #1;
    check_model();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] exp_w;
    int wcnt;

    //            wr rd fl din      cnt full af empty ae ovf udf ov ow
    tbl[0]  = '{1, 0, 0, 16'h0001, 1, 0, 0, 0, 1, 0, 0, 0, 16'h0000};
    tbl[1]  = '{1, 0, 0, 16'h0002, 2, 0, 0, 0, 0, 0, 0, 0, 16'h0000};
    tbl[2]  = '{1, 0, 0, 16'h0003, 3, 0, 0, 0, 0, 0, 0, 0, 16'h0000};
    tbl[3]  = '{1, 0, 0, 16'h0004, 4, 0, 0, 0, 0, 0, 0, 0, 16'h0000};
    tbl[4]  = '{1, 0, 0, 16'h0005, 5, 0, 1, 0, 0, 0, 0, 0, 16'h0000};
    tbl[5]  = '{1, 0, 0, 16'h0006, 6, 1, 1, 0, 0, 0, 0, 0, 16'h0000};
    tbl[6]  = '{1, 0, 0, 16'h0007, 6, 1, 1, 0, 0, 1, 0, 0, 16'h0000};
    tbl[7]  = '{0, 1, 0, 16'h0000, 5, 0, 1, 0, 0, 1, 0, 1, 16'h0001};
    tbl[8]  = '{0, 1, 0, 16'h0000, 4, 0, 0, 0, 0, 1, 0, 1, 16'h0002};
    tbl[9]  = '{0, 1, 0, 16'h0000, 3, 0, 0, 0, 0, 1, 0, 1, 16'h0003};
    tbl[10] = '{0, 1, 0, 16'h0000, 2, 0, 0, 0, 0, 1, 0, 1, 16'h0004};
    tbl[11] = '{0, 1, 0, 16'h0000, 1, 0, 0, 0, 1, 1, 0, 1, 16'h0005};
    tbl[12] = '{0, 1, 0, 16'h0000, 0, 0, 0, 1, 1, 1, 0, 1, 16'h0006};
    tbl[13] = '{0, 0, 0, 16'h0000, 0, 0, 0, 1, 1, 1, 0, 0, 16'h0006};
    tbl[14] = '{1, 1, 0, 16'h00AA, 1, 0, 0, 0, 1, 1, 1, 0, 16'h0006};
    tbl[15] = '{0, 0, 1, 16'h0000, 0, 0, 0, 1, 1, 0, 0, 0, 16'h0006};

    model_reset();
    @(negedge clk);
    check_model();
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].wr, tbl[i].rd, tbl[i].fl, tbl[i].din);
      chk($sformatf("tbl%0d_cnt", i), 32'(s_cnt), tbl[i].cnt);
      chk($sformatf("tbl%0d_flags", i), {s_full, s_af, s_empty, s_ae},
          {tbl[i].full, tbl[i].af, tbl[i].empty, tbl[i].ae});
      chk($sformatf("tbl%0d_err", i), {s_ovf, s_udf}, {tbl[i].ovf, tbl[i].udf});
      chk($sformatf("tbl%0d_out_valid", i), s_ov, tbl[i].ov);
      chk($sformatf("tbl%0d_out_word", i), s_ow, tbl[i].ow);
    end

    // Steady-state simultaneous read/write across the pointer wrap.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 16'(16'h0100 + i));
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 0, 16'(16'h0200 + i));
      exp_w = (i < 3) ? 16'(16'h0100 + i) : 16'(16'h0200 + i - 3);
      chk("wrap_word", s_ow, exp_w);
    end
    chk("wrap_cnt", 32'(s_cnt), 3);
    chk("wrap_err", {s_ovf, s_udf}, 2'b00);

    // Full with simultaneous read and write: write dropped, oldest popped.
    step(0, 0, 1, '0);
    for (int i = 0; i < D; i++) step(1, 0, 0, 16'(16'h0300 + i));
    step(1, 1, 0, 16'h03FF);
    chk("fullwr_cnt", 32'(s_cnt), 5);
    chk("fullwr_ovf", s_ovf, 1'b1);
    chk("fullwr_word", s_ow, 16'h0300);

    // Flush with both error flags set and a write in the same cycle.
    for (int i = 0; i < 5; i++) step(0, 1, 0, '0);
    step(0, 1, 0, '0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 16'(16'h0400 + i));
    chk("preflush", {s_cnt, s_ovf, s_udf}, {3'd4, 1'b1, 1'b1});
    step(1, 0, 1, 16'hBEEF);
    chk("flush_state", {s_cnt, s_empty, s_ovf, s_udf}, {3'd0, 1'b1, 1'b0, 1'b0});
    step(0, 0, 0, '0);
    chk("flush_nostore", {f_empty, f_ov}, 2'b10);

    // FWFT: first word visible without a read, and the pop empties it.
    step(1, 0, 0, 16'hABCD);
    chk("fwft_first", {f_empty, f_ov, f_ow}, {1'b0, 1'b1, 16'hABCD});
    step(0, 0, 0, '0);
    chk("fwft_hold", f_ow, 16'hABCD);
    step(0, 1, 0, '0);
    chk("fwft_pop", {f_empty, f_ae, f_ov}, 3'b110);
    chk("std_pop_word", s_ow, 16'hABCD);

    // Asynchronous reset between edges in the middle of a burst.
    step(0, 1, 0, '0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 16'(16'h0500 + i));
    fifo_wr = 1'b1; in_word = 16'h0555;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_std", {s_cnt, s_full, s_af, s_empty, s_ae, s_ov, s_ovf, s_udf},
        {3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    chk("arst_std_word", s_ow, 16'h0000);
    chk("arst_fwft", {f_cnt, f_empty, f_ov, f_ow}, {3'd0, 1'b1, 1'b0, 16'h0000});
    model_reset();
    @(posedge clk);
    #1 check_model();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, 16'h5555);
    chk("post_rst_cnt", 32'(s_cnt), 1);

    // Randomized traffic against the queue model.
    wcnt = 0;
    for (int i = 0; i < 400; i++) begin
      bit wr, rd, fl;
      wr = ($urandom_range(0, 99) < 55);
      rd = ($urandom_range(0, 99) < 50);
      fl = ($urandom_range(0, 59) == 0);
      step(wr, rd, fl, 16'($urandom));
      wcnt++;
    end
    chk("random_cycles", wcnt, 400);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
